// File: rtl/ledger_glyph_pkg.sv
// ledger_glyph_pkg: shared state, code names and default ledger patterns
package ledger_glyph_pkg;
  typedef enum logic {INIT, IDLE} lg_state_e;
  localparam int LG_BLANK = 0;
  localparam int LG_MIDDLE = 1;
  localparam int LG_ABOVE = 2;
  localparam int LG_BELOW = 3;
  localparam int LG_MAX_W = 64;
  // Rows are either fully lit or blank, so callers truncate the all-ones word to GLYPH_W.
  function automatic logic [LG_MAX_W-1:0] default_row(int code, int row, int h);
    logic lit;
    lit = (code == LG_MIDDLE && row == h / 2) || (code == LG_ABOVE && row == 0) ||
          (code == LG_BELOW && row == h - 1);
    return lit ? '1 : '0;
  endfunction
endpackage

// File: rtl/glyph_ram_1r1w.sv
// glyph_ram_1r1w: one write port, one registered read-before-write read port
module glyph_ram_1r1w #(
  parameter int W = 8,
  parameter int D = 32,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [D];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/ledger_glyph_engine.sv
// ledger_glyph_engine: self-initialising glyph RAM with a 2-stage per-pixel lookup
module ledger_glyph_engine
  import ledger_glyph_pkg::*;
#(
  parameter int GLYPH_W = 8,
  parameter int GLYPH_H = 8,
  parameter int NUM_CODES = 4,
  parameter int CODE_W = $clog2(NUM_CODES) + 1,
  parameter int ROW_W = $clog2(GLYPH_H),
  parameter int COL_W = $clog2(GLYPH_W)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pix_valid_in,
  input  logic [CODE_W-1:0] code_in,
  input  logic [ROW_W-1:0]  row_in,
  input  logic [COL_W-1:0]  col_in,
  output logic              pix_valid_out,
  output logic              pix_on,
  input  logic              wr_en,
  input  logic [CODE_W-2:0] wr_code,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [GLYPH_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              init_done
);
  localparam int DEPTH = NUM_CODES * GLYPH_H;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  lg_state_e state;
  logic [CW-1:0] cnt;
  logic [CODE_W-2:0] icode;
  logic [ROW_W-1:0] irow;
  logic rd_ok, we, v1, r1, pix_bit;
  logic [COL_W-1:0] c1, bidx;
  logic [AW-1:0] raddr, waddr;
  logic [GLYPH_W-1:0] wdata, rdata;
  // The RAM read is launched at issue, so a same-cycle write is not yet visible.
  always_comb begin
    rd_ok = state == IDLE && 32'(code_in) < NUM_CODES && 32'(row_in) < GLYPH_H;
    raddr = rd_ok ? AW'(32'(code_in) * GLYPH_H + 32'(row_in)) : '0;
    we = state == INIT || (wr_en && wr_ready && 32'(wr_code) < NUM_CODES && 32'(wr_row) < GLYPH_H);
    waddr = state == INIT ? cnt[AW-1:0] : AW'(32'(wr_code) * GLYPH_H + 32'(wr_row));
    wdata = state == INIT ? GLYPH_W'(default_row(int'(icode), int'(irow), GLYPH_H)) : wr_data;
    bidx = COL_W'(GLYPH_W - 1 - 32'(c1));
    pix_bit = 32'(c1) < GLYPH_W && rdata[bidx];
  end
  glyph_ram_1r1w #(.W(GLYPH_W), .D(DEPTH), .AW(AW)) u_ram (
    .clk(Clk),
    .we(we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(raddr),
    .rdata(rdata)
  );
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= INIT;
      cnt <= '0;
      icode <= '0;
      irow <= '0;
      wr_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b0;
      if (state == INIT) begin
        cnt <= cnt + 1'b1;
        irow <= 32'(irow) == GLYPH_H - 1 ? '0 : irow + 1'b1;
        icode <= 32'(irow) == GLYPH_H - 1 ? icode + 1'b1 : icode;
        if (32'(cnt) == DEPTH - 1) begin
          state <= IDLE;
          wr_ready <= 1'b1;
          init_done <= 1'b1;
        end
      end
    end
  end
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      v1 <= 1'b0;
      r1 <= 1'b0;
      c1 <= '0;
      pix_valid_out <= 1'b0;
      pix_on <= 1'b0;
    end else begin
      v1 <= pix_valid_in;
      r1 <= rd_ok;
      c1 <= col_in;
      pix_valid_out <= v1;
      pix_on <= v1 && r1 && pix_bit;
    end
  end
endmodule

// File: tb/tb_ledger_glyph_engine.sv
// tb_ledger_glyph_engine: directed scenarios for the default and a 16x12x6 engine
module tb_ledger_glyph_engine;
  logic Clk = 1'b0;
  logic Reset_n, pvi, pvo, pix_on, wr_en, wr_ready, init_done;
  logic [2:0] code_in, row_in, col_in, wr_row;
  logic [1:0] wr_code;
  logic [7:0] wr_data;
  logic rst2, v2in, vout2, pix2, wen2, wready2, idone2;
  logic [3:0] code2, row2, col2, wrow2;
  logic [2:0] wcode2;
  logic [15:0] wdata2;
  logic [7:0] em [4][8];
  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  ledger_glyph_engine dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_valid_in(pvi), .code_in(code_in), .row_in(row_in),
    .col_in(col_in), .pix_valid_out(pvo), .pix_on(pix_on), .wr_en(wr_en), .wr_code(wr_code),
    .wr_row(wr_row), .wr_data(wr_data), .wr_ready(wr_ready), .init_done(init_done)
  );

  ledger_glyph_engine #(.GLYPH_W(16), .GLYPH_H(12), .NUM_CODES(6)) dut2 (
    .Clk(Clk), .Reset_n(rst2), .pix_valid_in(v2in), .code_in(code2), .row_in(row2),
    .col_in(col2), .pix_valid_out(vout2), .pix_on(pix2), .wr_en(wen2), .wr_code(wcode2),
    .wr_row(wrow2), .wr_data(wdata2), .wr_ready(wready2), .init_done(idone2)
  );

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  task automatic set_defaults;
    for (int c = 0; c < 4; c++) for (int r = 0; r < 8; r++) em[c][r] = 8'h00;
    em[1][4] = 8'hFF;
    em[2][0] = 8'hFF;
    em[3][7] = 8'hFF;
  endtask

  task automatic test_reset;
    Reset_n = 1'b0; pvi = 1'b0; wr_en = 1'b0;
    step; step;
    if (pvo !== 1'b0) begin errors++; $display("FAIL reset_pvo got %b want 0", pvo); end checks++;
    if (pix_on !== 1'b0) begin errors++; $display("FAIL reset_pix got %b want 0", pix_on); end checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end checks++;
    if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", init_done); end checks++;
    Reset_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step;
      if (init_done !== (k == 32)) begin errors++; $display("FAIL init_done cyc%0d got %b want %b", k, init_done, k == 32); end checks++;
      if (wr_ready !== (k >= 32)) begin errors++; $display("FAIL wr_ready cyc%0d got %b want %b", k, wr_ready, k >= 32); end checks++;
    end
  endtask

  task automatic test_sweep(input string tag);
    logic pe, pp;
    pvi = 1'b0; wr_en = 1'b0;
    step; step;
    pe = 1'b0; pp = 1'b0;
    for (int c = 0; c < 4; c++) for (int r = 0; r < 8; r++) for (int col = 0; col < 8; col++) begin
      pvi = 1'b1; code_in = 3'(c); row_in = 3'(r); col_in = 3'(col);
      step;
      if (pvo !== pe) begin errors++; $display("FAIL %s_pvo req c%0d r%0d col%0d got %b want %b", tag, c, r, col, pvo, pe); end checks++;
      if (pix_on !== pp) begin errors++; $display("FAIL %s_pix req c%0d r%0d col%0d got %b want %b", tag, c, r, col, pix_on, pp); end checks++;
      pe = 1'b1;
      pp = em[c][r][7-col];
    end
    pvi = 1'b0;
    step;
    if (pvo !== 1'b1 || pix_on !== pp) begin errors++; $display("FAIL %s_tail got %b%b want 1%b", tag, pvo, pix_on, pp); end checks++;
    step;
    if (pvo !== 1'b0 || pix_on !== 1'b0) begin errors++; $display("FAIL %s_drain got %b%b want 00", tag, pvo, pix_on); end checks++;
  endtask

  task automatic test_write;
    wr_en = 1'b1; wr_code = 2'd0; wr_row = 3'd3; wr_data = 8'b1000_0001;
    pvi = 1'b1; code_in = 3'd0; row_in = 3'd3; col_in = 3'd0;
    step;
    wr_en = 1'b0;
    step;
    if (pvo !== 1'b1 || pix_on !== 1'b0) begin errors++; $display("FAIL wr_same_cycle got %b%b want 10", pvo, pix_on); end checks++;
    col_in = 3'd1;
    step;
    if (pix_on !== 1'b1) begin errors++; $display("FAIL wr_next_col0 got %b want 1", pix_on); end checks++;
    col_in = 3'd7;
    step;
    if (pix_on !== 1'b0) begin errors++; $display("FAIL wr_col1 got %b want 0", pix_on); end checks++;
    pvi = 1'b0;
    step;
    if (pix_on !== 1'b1) begin errors++; $display("FAIL wr_col7 got %b want 1", pix_on); end checks++;
    step;
    if (pvo !== 1'b0) begin errors++; $display("FAIL wr_drain got %b want 0", pvo); end checks++;
    em[0][3] = 8'b1000_0001;
  endtask

  task automatic test_back_to_back;
    int lr[4] = '{1, 1, 2, 2};
    int lc[4] = '{0, 1, 2, 0};
    logic ex[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    wr_en = 1'b1; wr_code = 2'd3; wr_row = 3'd1; wr_data = 8'hA5;
    step;
    wr_row = 3'd2; wr_data = 8'h3C;
    step;
    wr_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin pvi = 1'b1; code_in = 3'd3; row_in = 3'(lr[i]); col_in = 3'(lc[i]); end
      else pvi = 1'b0;
      step;
      if (i >= 1 && i <= 4) begin
        if (pvo !== 1'b1 || pix_on !== ex[i-1]) begin errors++; $display("FAIL b2b_%0d got %b%b want 1%b", i - 1, pvo, pix_on, ex[i-1]); end checks++;
      end
    end
    if (pvo !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", pvo); end checks++;
    em[3][1] = 8'hA5;
    em[3][2] = 8'h3C;
  endtask

  task automatic test_out_of_range;
    for (int i = 0; i < 6; i++) begin
      pvi = i < 4;
      code_in = i < 3 ? 3'd5 : 3'd4; row_in = i < 3 ? 3'd4 : 3'd0; col_in = 3'd0;
      step;
      if (i >= 1 && i <= 4) begin
        if (pvo !== 1'b1 || pix_on !== 1'b0) begin errors++; $display("FAIL oor_%0d got %b%b want 10", i - 1, pvo, pix_on); end checks++;
      end
    end
    if (pvo !== 1'b0) begin errors++; $display("FAIL oor_drain got %b want 0", pvo); end checks++;
  endtask

  task automatic test_init_lookup;
    Reset_n = 1'b0; pvi = 1'b0; wr_en = 1'b0;
    step;
    Reset_n = 1'b1; pvi = 1'b1; code_in = 3'd1; row_in = 3'd4; col_in = 3'd0;
    for (int k = 1; k <= 40; k++) begin
      step;
      if (pvo !== (k >= 2)) begin errors++; $display("FAIL initlk_pvo cyc%0d got %b want %b", k, pvo, k >= 2); end checks++;
      if (pix_on !== (k >= 34)) begin errors++; $display("FAIL initlk_pix cyc%0d got %b want %b", k, pix_on, k >= 34); end checks++;
      if (init_done !== (k == 32)) begin errors++; $display("FAIL initlk_done cyc%0d got %b want %b", k, init_done, k == 32); end checks++;
    end
    pvi = 1'b0;
    step; step;
  endtask

  task automatic test_reset_midsweep;
    wr_en = 1'b1; wr_code = 2'd2; wr_row = 3'd0; wr_data = 8'h00; pvi = 1'b0;
    step;
    wr_en = 1'b0; pvi = 1'b1; code_in = 3'd2; row_in = 3'd0; col_in = 3'd3;
    step; step;
    if (pvo !== 1'b1 || pix_on !== 1'b0) begin errors++; $display("FAIL mid_edit got %b%b want 10", pvo, pix_on); end checks++;
    Reset_n = 1'b0;
    step;
    if (pvo !== 1'b0 || pix_on !== 1'b0) begin errors++; $display("FAIL mid_reset_pipe got %b%b want 00", pvo, pix_on); end checks++;
    if (wr_ready !== 1'b0) begin errors++; $display("FAIL mid_reset_ready got %b want 0", wr_ready); end checks++;
    Reset_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step;
      if (init_done !== (k == 32)) begin errors++; $display("FAIL mid_done cyc%0d got %b want %b", k, init_done, k == 32); end checks++;
      if (wr_ready !== (k >= 32)) begin errors++; $display("FAIL mid_ready cyc%0d got %b want %b", k, wr_ready, k >= 32); end checks++;
      if (pix_on !== (k >= 34)) begin errors++; $display("FAIL mid_pix cyc%0d got %b want %b", k, pix_on, k >= 34); end checks++;
    end
    pvi = 1'b0;
    set_defaults();
  endtask

  task automatic test_param;
    int tc[14] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 0, 6, 5, 5, 5};
    int tr[14] = '{6, 6, 5, 7, 0, 1, 11, 10, 0, 6, 6, 3, 3, 3};
    int tl[14] = '{0, 15, 0, 3, 9, 9, 15, 0, 0, 0, 0, 0, 1, 15};
    logic ex[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    rst2 = 1'b0;
    step;
    rst2 = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      step;
      if (idone2 !== (k == 72)) begin errors++; $display("FAIL p_done cyc%0d got %b want %b", k, idone2, k == 72); end checks++;
      if (wready2 !== (k >= 72)) begin errors++; $display("FAIL p_ready cyc%0d got %b want %b", k, wready2, k >= 72); end checks++;
    end
    wen2 = 1'b1; wcode2 = 3'd5; wrow2 = 4'd3; wdata2 = 16'h8001;
    step;
    wen2 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i < 14) begin v2in = 1'b1; code2 = 4'(tc[i]); row2 = 4'(tr[i]); col2 = 4'(tl[i]); end
      else v2in = 1'b0;
      step;
      if (i >= 1) begin
        if (vout2 !== 1'b1 || pix2 !== ex[i-1]) begin errors++; $display("FAIL p_lk c%0d r%0d col%0d got %b%b want 1%b", tc[i-1], tr[i-1], tl[i-1], vout2, pix2, ex[i-1]); end checks++;
      end
    end
    step;
    if (vout2 !== 1'b0) begin errors++; $display("FAIL p_drain got %b want 0", vout2); end checks++;
  endtask

  initial begin
    Reset_n = 1'b0; pvi = 1'b0; code_in = '0; row_in = '0; col_in = '0;
    wr_en = 1'b0; wr_code = '0; wr_row = '0; wr_data = '0;
    rst2 = 1'b0; v2in = 1'b0; code2 = '0; row2 = '0; col2 = '0;
    wen2 = 1'b0; wcode2 = '0; wrow2 = '0; wdata2 = '0;
    test_reset();
    set_defaults();
    test_sweep("default");
    test_write();
    test_back_to_back();
    test_out_of_range();
    test_sweep("post_oor");
    test_init_lookup();
    set_defaults();
    test_reset_midsweep();
    test_sweep("post_reset");
    test_param();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
